// File: rtl/dcache_direct_wb.sv
// Direct-mapped, write-back, write-allocate data cache sitting between the MEM stage
// and a line-granular backing memory. Misses evict, fill, then retry as a normal hit.
module dcache_direct_wb #(
    parameter int NUM_SETS   = 16,
    parameter int LINE_BYTES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         is_input_valid,
    input  logic [31:0]  addr,
    input  logic         mem_rw,
    input  logic [31:0]  din,
    output logic         is_ready,
    output logic         is_output_valid,
    output logic [31:0]  dout,
    output logic         is_hit,
    output logic         mem_req_valid,
    output logic         mem_req_write,
    output logic [31:0]  mem_req_addr,
    output logic [127:0] mem_req_data,
    input  logic         mem_req_ready,
    input  logic         mem_resp_valid,
    input  logic [127:0] mem_resp_data,
    output logic [31:0]  num_hits,
    output logic [31:0]  num_accesses
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 32 - OFF_W - IDX_W;
    localparam int WORDS = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_ALLOCATE,
        S_WAIT_FILL
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic [NUM_SETS-1:0] dirty_q, dirty_d;
    logic [31:0]         num_hits_q, num_hits_d;
    logic [31:0]         num_accesses_q, num_accesses_d;

    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [127:0]        data_q [NUM_SETS];

    logic [1:0]          req_word;
    logic [IDX_W-1:0]    req_index;
    logic [TAG_W-1:0]    req_tag;
    logic [TAG_W-1:0]    line_tag;
    logic [127:0]        line_data;
    logic [127:0]        store_line;
    logic [31:0]         hit_word;
    logic                lookup_hit;
    logic                victim_dirty;
    logic                addr_unused;

    logic                line_we;
    logic                tag_we;
    logic [127:0]        line_wdata;

    assign req_word    = addr[3:2];
    assign req_index   = addr[OFF_W +: IDX_W];
    assign req_tag     = addr[31 -: TAG_W];
    assign addr_unused = ^addr[1:0];

    // Tag/data arrays are read asynchronously: the lookup must resolve in the request cycle.
    assign line_tag     = tag_q[req_index];
    assign line_data    = data_q[req_index];
    assign hit_word     = line_data[{req_word, 5'b0} +: 32];
    assign lookup_hit   = is_input_valid & valid_q[req_index] & (line_tag == req_tag);
    assign victim_dirty = valid_q[req_index] & dirty_q[req_index];

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_store_merge
            assign store_line[32*gi +: 32] = (req_word == 2'(gi)) ? din
                                                                 : line_data[32*gi +: 32];
        end
    endgenerate

    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        dirty_d         = dirty_q;
        num_hits_d      = num_hits_q;
        num_accesses_d  = num_accesses_q;
        line_we         = 1'b0;
        tag_we          = 1'b0;
        line_wdata      = store_line;
        is_ready        = 1'b0;
        is_output_valid = 1'b0;
        is_hit          = 1'b0;
        dout            = '0;
        mem_req_valid   = 1'b0;
        mem_req_write   = 1'b0;
        mem_req_addr    = '0;
        mem_req_data    = '0;

        case (state_q)
            S_IDLE: begin
                is_ready = 1'b1;
                if (lookup_hit) begin
                    is_output_valid = 1'b1;
                    is_hit          = 1'b1;
                    dout            = hit_word;
                    num_hits_d      = num_hits_q + 32'd1;
                    num_accesses_d  = num_accesses_q + 32'd1;
                    if (mem_rw) begin
                        line_we            = 1'b1;
                        dirty_d[req_index] = 1'b1;
                    end
                end else if (is_input_valid) begin
                    state_d = victim_dirty ? S_WRITEBACK : S_ALLOCATE;
                end
            end

            S_WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = {line_tag, req_index, {OFF_W{1'b0}}};
                mem_req_data  = line_data;
                if (mem_req_ready) begin
                    dirty_d[req_index] = 1'b0;
                    state_d            = S_ALLOCATE;
                end
            end

            S_ALLOCATE: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag, req_index, {OFF_W{1'b0}}};
                if (mem_req_ready) begin
                    state_d = S_WAIT_FILL;
                end
            end

            S_WAIT_FILL: begin
                if (mem_resp_valid) begin
                    line_we            = 1'b1;
                    tag_we             = 1'b1;
                    line_wdata         = mem_resp_data;
                    valid_d[req_index] = 1'b1;
                    dirty_d[req_index] = 1'b0;
                    state_d            = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            valid_q        <= '0;
            dirty_q        <= '0;
            num_hits_q     <= '0;
            num_accesses_q <= '0;
        end else begin
            state_q        <= state_d;
            valid_q        <= valid_d;
            dirty_q        <= dirty_d;
            num_hits_q     <= num_hits_d;
            num_accesses_q <= num_accesses_d;
        end
    end

    // Array contents need no reset; the valid bits alone decide what is live.
    always_ff @(posedge clk) begin
        if (!reset && line_we) begin
            data_q[req_index] <= line_wdata;
        end
        if (!reset && tag_we) begin
            tag_q[req_index] <= req_tag;
        end
    end

    assign num_hits     = num_hits_q;
    assign num_accesses = num_accesses_q;

endmodule

// File: doc/dcache_direct_wb.md
Name: dcache_direct_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM stage and a block-granular backing memory.
- Replaces the direct MEM-stage → data memory connection.
- The pipeline stalls on `is_ready`/`is_output_valid`.
- Exposes hit/access counters for the simulation report.

Parameters:
- NUM_SETS, 16, number of lines; power of 2.
- LINE_BYTES, 16, bytes per line (4 words); fixed at 16.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- is_input_valid  input  1  CPU request present
- addr  input  32  byte address; bits [1:0] ignored
- mem_rw  input  1  0 = load, 1 = store
- din  input  32  store data
- is_ready  output  1  cache in IDLE, able to look up
- is_output_valid  output  1  request completed this cycle
- dout  output  32  load data; valid with is_output_valid
- is_hit  output  1  lookup hit this cycle
- mem_req_valid  output  1  backing-memory request
- mem_req_write  output  1  1 = line writeback, 0 = line fill
- mem_req_addr  output  32  line-aligned address, low 4 bits 0
- mem_req_data  output  128  writeback line
- mem_req_ready  input  1  memory accepts request
- mem_resp_valid  input  1  fill data valid, 1-cycle pulse
- mem_resp_data  input  128  fill line
- num_hits  output  32  count of hit completions
- num_accesses  output  32  count of completed requests

Behaviour:
- Address split:
  - word = addr[3:2]
  - index = addr[4+log2(NUM_SETS)-1:4]
  - tag = remaining upper bits
- Per-line state: valid, dirty, tag, 128-bit data.
  - Word w occupies data bits [32w+31:32w].
- States: IDLE, WRITEBACK, ALLOCATE, WAIT_FILL. Reset puts the FSM in IDLE.
- Reset values:
  - All valid and dirty bits cleared.
  - Counters 0.
  - is_ready 1; is_output_valid 0, dout 0, is_hit 0.
  - mem_req_valid 0, mem_req_write 0, mem_req_addr 0, mem_req_data 0.
- Reset mid-operation: an outstanding fill is abandoned and any late mem_resp_valid is ignored. Dirty data is discarded.
- IDLE, lookup:
  - is_ready = 1.
  - hit = is_input_valid & valid[index] & tag match.
  - Lookup is combinational.
- Hit in IDLE:
  - is_output_valid = 1 and is_hit = 1 in the same cycle.
  - Load: dout = selected word.
  - Store: the word is written and dirty set at the next posedge.
  - Counters: num_hits++ and num_accesses++ at that edge.
- Miss in IDLE:
  - is_output_valid = 0 and is_hit = 0.
  - Next state is WRITEBACK if the victim is valid & dirty, else ALLOCATE.
- Outside IDLE:
  - is_ready = 0, is_output_valid = 0, is_hit = 0.
  - The CPU must hold addr, mem_rw, din and is_input_valid stable until is_output_valid.
  - A request that changes mid-miss is undefined and not checked.
- WRITEBACK:
  - mem_req_valid = 1, mem_req_write = 1.
  - mem_req_addr = {victim tag, index, 4'b0}; mem_req_data = victim line.
  - Request held stable until mem_req_ready.
  - On acceptance (valid & ready edge): clear dirty, go to ALLOCATE. No write response is expected.
- ALLOCATE:
  - mem_req_valid = 1, mem_req_write = 0.
  - mem_req_addr = {request tag, index, 4'b0}.
  - Held until mem_req_ready; on acceptance go to WAIT_FILL.
- WAIT_FILL:
  - mem_req_valid = 0.
  - On mem_resp_valid: line data = mem_resp_data, tag = request tag, valid = 1, dirty = 0. Go to IDLE.
- Retry after fill: in IDLE the held request hits and completes as a normal hit.
  - It is counted as one access and one hit, so num_hits includes post-fill retries.
  - Minimum miss latency (clean victim, ready and response immediate) is 3 cycles from the first lookup to is_output_valid:
    - lookup → ALLOCATE
    - ALLOCATE → WAIT_FILL
    - response edge → IDLE hit
- Store miss: write-allocate. Fill first, then the retry hit writes the word and sets dirty.
- mem_resp_valid outside WAIT_FILL is ignored.
- Counters wrap modulo 2^32.
- No write-through and no flush port. Dirty lines leave the cache only on eviction.

Test Plan:
- Cold load 0x0000_0010, memory returns line {0x44,0x33,0x22,0x11} (word3..word0) → 1 WAIT_FILL response, then is_output_valid with dout = 0x11, is_hit = 1; num_accesses = 1.
- Load 0x14 right after → same-cycle hit, dout = 0x22; num_hits = 2, num_accesses = 2.
- Store 0xDEAD_BEEF to 0x18 (hit), then load 0x0000_0118 (same index 1, different tag):
  - Expect a WRITEBACK request, addr 0x10, with data word2 = 0xDEADBEEF.
  - Then a fill request, addr 0x110.
  - Load returns the new line's word 2.
- mem_req_ready held low for 5 cycles in ALLOCATE → mem_req_valid and mem_req_addr stable all 5 cycles; no state advance.
- Store miss to empty set 0x0000_0024 data 0x1234 → fill request, then the retry writes the word. A later eviction of that set writes back a line containing 0x1234 at word 1.
- Reset asserted in WAIT_FILL, then mem_resp_valid pulses → FSM in IDLE, all lines invalid, counters 0. The next load to the same address misses.
